// File: rtl/axi_slave_wr.sv
// AXI write-channel slave (AW/W/B) backed by a byte-lane local memory.
// One burst outstanding at a time; a single B response per burst; debug read port.
module axi_slave_wr #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int MEM_WORDS = 256
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic [ADDR_BITS-1:0]         aw_addr,
    input  logic [LEN_BITS-1:0]          aw_len,
    input  logic [SIZE_BITS-1:0]         aw_size,
    input  logic [1:0]                   aw_burst,
    input  logic [3:0]                   aw_cache,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [DATA_BITS-1:0]         w_data,
    input  logic [DATA_BITS/8-1:0]       w_strb,
    input  logic                         w_last,
    input  logic                         w_valid,
    output logic                         w_ready,
    output logic                         b_valid,
    output logic [1:0]                   b_resp,
    input  logic                         b_ready,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [DATA_BITS-1:0]         dbg_data
);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int LANE_BITS = $clog2(STRB_BITS);
    localparam int WIDX_BITS = $clog2(MEM_WORDS);
    localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'(LANE_BITS);
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t                 state_reg;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic [LEN_BITS-1:0]    len_reg;
    logic [SIZE_BITS-1:0]   size_reg;
    logic [1:0]             burst_reg;
    logic [LEN_BITS-1:0]    beat_cnt_reg;
    logic                   err_reg;

    logic                   beat;
    logic                   burst_err;
    logic                   range_err;
    logic                   last_at_len;
    logic                   beat_err;
    logic                   burst_end;
    logic                   wr_en;
    logic [WIDX_BITS-1:0]   wr_idx;
    logic [ADDR_BITS-1:0]   beat_bytes;
    logic [ADDR_BITS-1:0]   addr_next;
    logic                   unused_cache;

    assign unused_cache = ^aw_cache;

    // Burst-level errors suppress every write of the burst; beat-level ones only that beat.
    assign beat        = (state_reg == S_DATA) && w_valid && w_ready;
    assign burst_err   = (size_reg > MAX_SIZE) || burst_reg[1];
    assign range_err   = |(addr_reg >> (LANE_BITS + WIDX_BITS));
    assign last_at_len = (beat_cnt_reg == len_reg);
    assign beat_err    = range_err || (w_last != last_at_len);
    assign burst_end   = last_at_len || w_last;
    assign wr_en       = areset_n && beat && !burst_err && !beat_err;
    assign wr_idx      = addr_reg[LANE_BITS +: WIDX_BITS];

    // INCR steps from the size-aligned address, so an unaligned start aligns after beat 0.
    assign beat_bytes = ADDR_BITS'(1) << size_reg;
    assign addr_next  = (burst_reg == BURST_INCR)
                      ? ((addr_reg & ~(beat_bytes - ADDR_BITS'(1))) + beat_bytes)
                      : addr_reg;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_reg    <= S_IDLE;
            aw_ready     <= 1'b0;
            w_ready      <= 1'b0;
            b_valid      <= 1'b0;
            b_resp       <= RESP_OKAY;
            err_reg      <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    aw_ready <= 1'b1;
                    if (aw_valid && aw_ready) begin
                        addr_reg     <= aw_addr;
                        len_reg      <= aw_len;
                        size_reg     <= aw_size;
                        burst_reg    <= aw_burst;
                        beat_cnt_reg <= '0;
                        err_reg      <= 1'b0;
                        aw_ready     <= 1'b0;
                        w_ready      <= 1'b1;
                        state_reg    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + LEN_BITS'(1);
                        addr_reg     <= addr_next;
                        if (burst_err || beat_err) begin
                            err_reg <= 1'b1;
                        end
                        if (burst_end) begin
                            w_ready   <= 1'b0;
                            b_valid   <= 1'b1;
                            b_resp    <= (err_reg || burst_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state_reg <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (b_ready) begin
                        b_valid   <= 1'b0;
                        b_resp    <= RESP_OKAY;
                        aw_ready  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    aw_ready  <= 1'b0;
                    w_ready   <= 1'b0;
                    b_valid   <= 1'b0;
                end
            endcase
        end
    end

    // One memory per byte lane keeps strobed writes independent and never reset.
    generate
        for (genvar gi = 0; gi < STRB_BITS; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];

            always_ff @(posedge aclk) begin
                if (wr_en && w_strb[gi]) begin
                    lane_mem[wr_idx] <= w_data[gi*8 +: 8];
                end
            end

            assign dbg_data[gi*8 +: 8] = lane_mem[dbg_addr];
        end
    endgenerate
endmodule

// File: tb/tb_axi_slave_wr.sv
// Directed bench for axi_slave_wr: table of bursts plus reset, backpressure and abort sequences.
module tb_axi_slave_wr;
    logic        aclk;
    logic        areset_n;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_cache;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        b_ready;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    axi_slave_wr dut (
        .aclk(aclk), .areset_n(areset_n),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_cache(aw_cache), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        string            name;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               nbeats;
        int               last_beat;
        logic [3:0][31:0] data;
        logic [3:0][3:0]  strb;
        logic [1:0]       exp_resp;
        int               nchk;
        logic [3:0][7:0]  chk_idx;
        logic [3:0][31:0] chk_val;
    } vec_t;

    vec_t vecs [13];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic rd_chk(input string name, input logic [7:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk($sformatf("%s mem[%0d]", name, idx), dbg_data, exp);
    endtask

    task automatic send_aw(input string name, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int n;
        aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
        n = 0;
        while (!aw_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) chk({name, " aw_ready timeout"}, 32'(aw_ready), 32'd1);
        @(negedge aclk);
        aw_valid = 1'b0;
        chk({name, " aw_ready low after accept"}, 32'(aw_ready), 32'd0);
    endtask

    task automatic send_beat(input string name, input logic [31:0] d, input logic [3:0] s,
                             input logic l, input int gap);
        int n;
        repeat (gap) @(negedge aclk);
        w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
        n = 0;
        while (!w_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) chk({name, " w_ready timeout"}, 32'(w_ready), 32'd1);
        @(negedge aclk);
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic do_burst(input vec_t v, input int bdelay);
        int n;
        logic [1:0] held;
        send_aw(v.name, v.addr, v.len, v.size, v.burst);
        for (int i = 0; i < v.nbeats; i++) begin
            send_beat(v.name, v.data[i], v.strb[i], (i == v.last_beat), $urandom_range(0, 2));
        end
        n = 0;
        while (!b_valid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk({v.name, " b_valid"}, 32'(b_valid), 32'd1);
        held = b_resp;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge aclk);
            chk({v.name, " b_valid held"}, 32'(b_valid), 32'd1);
            chk({v.name, " b_resp held"}, 32'(b_resp), 32'(held));
            chk({v.name, " aw_ready while B pending"}, 32'(aw_ready), 32'd0);
        end
        chk({v.name, " b_resp"}, 32'(b_resp), 32'(v.exp_resp));
        b_ready = 1'b1;
        @(negedge aclk);
        b_ready = 1'b0;
        chk({v.name, " b_valid dropped"}, 32'(b_valid), 32'd0);
        chk({v.name, " aw_ready after B"}, 32'(aw_ready), 32'd1);
        for (int c = 0; c < v.nchk; c++) begin
            rd_chk(v.name, v.chk_idx[c], v.chk_val[c]);
        end
        $display("[TB] burst %s addr=0x%08h len=%0d resp=%0d", v.name, v.addr, v.len, v.exp_resp);
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] a, input logic [7:0] l,
                                input logic [2:0] s, input logic [1:0] b, input int nb,
                                input int lb, input logic [3:0][31:0] d, input logic [3:0][3:0] st,
                                input logic [1:0] r, input int nc, input logic [3:0][7:0] ci,
                                input logic [3:0][31:0] cv);
        vec_t v;
        v.name = name; v.addr = a; v.len = l; v.size = s; v.burst = b; v.nbeats = nb;
        v.last_beat = lb; v.data = d; v.strb = st; v.exp_resp = r; v.nchk = nc;
        v.chk_idx = ci; v.chk_val = cv;
        return v;
    endfunction

    initial begin
        vec_t v;
        // Array element 0 is the last (lowest) item of each concatenation.
        vecs[0]  = mk("incr4",    32'h10,  8'd3, 3'd2, 2'b01, 4, 3,
                      {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {4'hF, 4'hF, 4'hF, 4'hF}, 2'b00,
                      4, {8'd7, 8'd6, 8'd5, 8'd4}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        vecs[1]  = mk("fixed3",   32'h8,   8'd2, 3'd2, 2'b00, 3, 2,
                      {32'h0, 32'h3, 32'h2, 32'h1}, {4'hF, 4'hF, 4'h2, 4'h1}, 2'b00,
                      1, {8'd0, 8'd0, 8'd0, 8'd2}, {32'h0, 32'h0, 32'h0, 32'h3});
        vecs[2]  = mk("preload0", 32'h0,   8'd0, 3'd2, 2'b01, 1, 0,
                      {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b00,
                      1, {8'd0, 8'd0, 8'd0, 8'd0}, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF});
        vecs[3]  = mk("strbmerge", 32'h0,  8'd0, 3'd2, 2'b01, 1, 0,
                      {32'h0, 32'h0, 32'h0, 32'h12345678}, {4'h0, 4'h0, 4'h0, 4'h5}, 2'b00,
                      1, {8'd0, 8'd0, 8'd0, 8'd0}, {32'h0, 32'h0, 32'h0, 32'hFF34FF78});
        vecs[4]  = mk("range",    32'h3FC, 8'd1, 3'd2, 2'b01, 2, 1,
                      {32'h0, 32'h0, 32'h22, 32'h11}, {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10,
                      2, {8'd0, 8'd0, 8'd0, 8'd255}, {32'h0, 32'h0, 32'hFF34FF78, 32'h11});
        vecs[5]  = mk("preload8", 32'h20,  8'd1, 3'd2, 2'b01, 2, 1,
                      {32'h0, 32'h0, 32'hC1, 32'hC0}, {4'h0, 4'h0, 4'hF, 4'hF}, 2'b00,
                      2, {8'd0, 8'd0, 8'd9, 8'd8}, {32'h0, 32'h0, 32'hC1, 32'hC0});
        vecs[6]  = mk("wrap",     32'h20,  8'd1, 3'd2, 2'b10, 2, 1,
                      {32'h0, 32'h0, 32'h66, 32'h55}, {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10,
                      2, {8'd0, 8'd0, 8'd9, 8'd8}, {32'h0, 32'h0, 32'hC1, 32'hC0});
        vecs[7]  = mk("preload16", 32'h40, 8'd3, 3'd2, 2'b01, 4, 3,
                      {32'hD3, 32'hD2, 32'hD1, 32'hD0}, {4'hF, 4'hF, 4'hF, 4'hF}, 2'b00,
                      2, {8'd0, 8'd0, 8'd17, 8'd16}, {32'h0, 32'h0, 32'hD1, 32'hD0});
        vecs[8]  = mk("earlylast", 32'h40, 8'd3, 3'd2, 2'b01, 2, 1,
                      {32'h0, 32'h0, 32'hE1, 32'hE0}, {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10,
                      2, {8'd0, 8'd0, 8'd17, 8'd16}, {32'h0, 32'h0, 32'hD1, 32'hE0});
        vecs[9]  = mk("nolast",   32'h50,  8'd1, 3'd2, 2'b01, 2, -1,
                      {32'h0, 32'h0, 32'hF1, 32'hF0}, {4'h0, 4'h0, 4'hF, 4'hF}, 2'b10,
                      1, {8'd0, 8'd0, 8'd0, 8'd20}, {32'h0, 32'h0, 32'h0, 32'hF0});
        vecs[10] = mk("sizeerr",  32'h40,  8'd0, 3'd3, 2'b01, 1, 0,
                      {32'h0, 32'h0, 32'h0, 32'h99}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10,
                      1, {8'd0, 8'd0, 8'd0, 8'd16}, {32'h0, 32'h0, 32'h0, 32'hE0});
        vecs[11] = mk("narrow",   32'h80,  8'd3, 3'd0, 2'b01, 4, 3,
                      {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                      {4'h8, 4'h4, 4'h2, 4'h1}, 2'b00,
                      1, {8'd0, 8'd0, 8'd0, 8'd32}, {32'h0, 32'h0, 32'h0, 32'h44332211});
        vecs[12] = mk("reserved", 32'h80,  8'd0, 3'd2, 2'b11, 1, 0,
                      {32'h0, 32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10,
                      1, {8'd0, 8'd0, 8'd0, 8'd32}, {32'h0, 32'h0, 32'h0, 32'h44332211});

        areset_n = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_cache = 4'h3;
        aw_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0; dbg_addr = '0;

        repeat (3) @(negedge aclk);
        chk("reset aw_ready", 32'(aw_ready), 32'd0);
        chk("reset w_ready", 32'(w_ready), 32'd0);
        chk("reset b_valid", 32'(b_valid), 32'd0);
        chk("reset b_resp", 32'(b_resp), 32'd0);
        areset_n = 1'b1;
        w_valid = 1'b1;
        @(negedge aclk);
        chk("aw_ready one cycle after reset", 32'(aw_ready), 32'd1);
        chk("W before AW stalls", 32'(w_ready), 32'd0);
        @(negedge aclk);
        chk("W before AW still stalled", 32'(w_ready), 32'd0);
        w_valid = 1'b0;
        $display("[TB] reset and early-W checks done");

        for (int i = 0; i < 13; i++) begin
            do_burst(vecs[i], 0);
        end

        v = mk("bp", 32'hC0, 8'd0, 3'd2, 2'b01, 1, 0,
               {32'h0, 32'h0, 32'h0, 32'h0000BEEF}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b00,
               1, {8'd0, 8'd0, 8'd0, 8'd48}, {32'h0, 32'h0, 32'h0, 32'h0000BEEF});
        do_burst(v, 5);
        v = mk("bperr", 32'hC0, 8'd0, 3'd2, 2'b10, 1, 0,
               {32'h0, 32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b10,
               1, {8'd0, 8'd0, 8'd0, 8'd48}, {32'h0, 32'h0, 32'h0, 32'h0000BEEF});
        do_burst(v, 5);

        send_aw("abort", 32'hA0, 8'd3, 3'd2, 2'b01);
        send_beat("abort", 32'h77, 4'hF, 1'b0, 0);
        send_beat("abort", 32'h88, 4'hF, 1'b0, 1);
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("abort no b_valid", 32'(b_valid), 32'd0);
            @(negedge aclk);
        end
        rd_chk("abort", 8'd40, 32'h77);
        rd_chk("abort", 8'd41, 32'h88);
        $display("[TB] reset mid-burst abort checked");
        v = mk("after_abort", 32'hA0, 8'd0, 3'd2, 2'b01, 1, 0,
               {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A}, {4'h0, 4'h0, 4'h0, 4'hF}, 2'b00,
               2, {8'd0, 8'd0, 8'd41, 8'd40}, {32'h0, 32'h0, 32'h88, 32'h5A5A5A5A});
        do_burst(v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slave_wr.md
Name:
axi_slave_wr

Overview:
AXI write-channel responder: the slave end of the AW/W/B channels, backed by a local word-addressed memory. It accepts one burst at a time, writes the strobed bytes of each beat, and returns a single B response per burst. It is the bus-level counterpart to the master write path and serves as the write target in the RTL and in block-level benches. A side debug port gives direct read access to the memory for checking.

Parameters:
ADDR_BITS, 32, width of aw_addr.
DATA_BITS, 32, data width; power of 2, 8..128.
LEN_BITS, 8, width of aw_len (beats = aw_len+1).
SIZE_BITS, 3, width of aw_size (bytes/beat = 2**aw_size).
MEM_WORDS, 256, memory depth in DATA_BITS words; power of 2.

Ports:
aclk  in  1  clock; all logic rising-edge.
areset_n  in  1  synchronous active-low reset.
aw_addr  in  ADDR_BITS  burst start byte address.
aw_len  in  LEN_BITS  beats minus one.
aw_size  in  SIZE_BITS  log2 bytes per beat.
aw_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
aw_cache  in  4  accepted, ignored.
aw_valid  in  1  AW valid.
aw_ready  out  1  AW ready.
w_data  in  DATA_BITS  write data.
w_strb  in  DATA_BITS/8  byte-lane enables.
w_last  in  1  final beat marker.
w_valid  in  1  W valid.
w_ready  out  1  W ready.
b_valid  out  1  response valid.
b_resp  out  2  00 OKAY, 10 SLVERR.
b_ready  in  1  response ready.
dbg_addr  in  $clog2(MEM_WORDS)  debug word index.
dbg_data  out  DATA_BITS  combinational mem[dbg_addr].

Behaviour:
- Reset (areset_n=0 at posedge): state IDLE; aw_ready, w_ready, b_valid = 0; b_resp = 00; error flag and beat counter cleared. Memory contents are not reset. Reset mid-burst abandons the burst with no B response; bytes already written stay written.
- All handshake outputs are registered. aw_ready rises 1 cycle after reset is released.
- IDLE: aw_ready=1, w_ready=0. On aw_valid&aw_ready, latch addr/len/size/burst, clear beat counter and error flag, and go to DATA (aw_ready=0, w_ready=1 next cycle). W beats presented before AW is accepted stall; they are not buffered.
- DATA: a beat is taken on w_valid&w_ready. Word index = addr[log2(DATA_BITS/8) +: log2(MEM_WORDS)]. Each byte lane with w_strb=1 is written the same cycle. Byte lanes with w_strb=0 keep their old value.
- Address update: INCR adds 2**size after each beat, unaligned start is aligned after the first beat, and there is no 4KB check. FIXED keeps the address constant.
- Error conditions. Any of these sets the error flag; the flagged beat(s), or all beats for a burst-level error, are not written, but every beat is still consumed:
  - size > log2(DATA_BITS/8);
  - burst WRAP or reserved;
  - beat address >= MEM_WORDS*DATA_BITS/8;
  - w_last=1 before beat len;
  - w_last=0 on beat len.
- End of burst: the burst ends on the beat where counter==len or w_last=1, whichever comes first. Go to RESP: w_ready=0, b_valid=1, b_resp = error ? 10 : 00.
- RESP: hold b_valid and b_resp until b_valid&b_ready, then go to IDLE with aw_ready=1 the next cycle. Only one burst is outstanding, so minimum burst-to-burst spacing is 1 (AW) + N (beats) + 1 (B) cycles.
- len=0: a single beat; w_last is expected on that beat.
- dbg_data: pure combinational read; it reflects a write from the cycle after the write's edge.

Test Plan:
- Reset then AW {addr 0x10, len 3, size 2, INCR}, 4 beats 0xA0..0xA3, strb F, last on beat 3 -> words 4..7 = A0..A3; b_resp 00; aw_ready low from AW accept until 1 cycle after B handshake.
- FIXED len 2 to 0x8, data 1,2,3 with strb 1,2,F -> word 2 = 0x00000003; b_resp 00.
- Strobe merge: preload word 0 = 0xFFFFFFFF, INCR len 0 data 0x12345678 strb 0101 -> word 0 = 0xFF34FF78.
- Errors: addr 0x3FC INCR len 1 -> word 255 written, beat 2 out of range not written, SLVERR. WRAP burst -> no writes, SLVERR. w_last on beat 1 of len 3 -> B after beat 1, SLVERR.
- Backpressure: b_ready low 5 cycles -> b_valid and b_resp stable, aw_ready=0 throughout; random w_valid gaps -> data unchanged.
- Reset asserted after beat 1 of a len-3 burst -> b_valid never asserts, word of beat 0 retains its value, next burst completes normally.
